// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port and occupancy flags.
// Latency: a write at edge N is readable from edge N+1; read data appears one edge after rd_en is sampled.
// Backpressure: a write into a full FIFO is accepted only if a read is accepted on the same edge; rejected operations pulse overflow/underflow.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Pointers wrap by plain overflow, so the depth has to be a power of two.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 4");
  end

  // Note: rst_n is an active-HIGH synchronous reset despite its name.
  logic                  rst;
  assign rst = rst_n;

  // Storage array; never reset, contents are only meaningful behind the pointers.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]         count_q,     count_d;
  logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
  logic                  rd_valid_q,  rd_valid_d;
  logic                  overflow_q,  overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full_w;
  logic                  empty_w;
  logic                  wr_accept;
  logic                  rd_accept;

  // Status flags come straight from the registered count, so no input reaches an output combinationally.
  always_comb begin
    full_w  = (count_q == FULL_LVL);
    empty_w = (count_q == '0);
  end

  // Accept decisions. A full FIFO still takes a write when a read frees a slot on the same edge;
  // an empty FIFO never lets a same-cycle write fall through to the read port.
  always_comb begin
    rd_accept = rd_en && !empty_w;
    wr_accept = wr_en && (!full_w || rd_en);
  end

  // Next-state for pointers, occupancy, read port and error pulses.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = wr_en && full_w && !rd_en;
    underflow_d = rd_en && empty_w;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset wins over any concurrent request and discards the contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Memory write port; suppressed during reset so a stray write strobe cannot land.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Output mapping.
  always_comb begin
    rd_data      = rd_data_q;
    rd_valid     = rd_valid_q;
    full         = full_w;
    empty        = empty_w;
    almost_full  = (count_q >= AF_LVL);
    almost_empty = (count_q <= AE_LVL);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_WIDTH=8, DEPTH=16).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at that same point.
// Each scenario task performs its own comparisons against hand-computed values.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    wr_en = 1'bx;
    rd_en = 1'bx;
    wr_data = 8'hxx;
    repeat (3) cycle();
    rst_n = 1'b0;
    idle();
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b want=1", empty); end else passes++;
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b want=0", full); end else passes++;
    checks++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got=%0d want=0", count); end else passes++;
    checks++; if (rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end else passes++;
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end else passes++;
    checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin fails++; $display("FAIL reset_almost got ae=%b af=%b want ae=1 af=0", almost_empty, almost_full); end else passes++;
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL reset_pulses got ov=%b un=%b want 0/0", overflow, underflow); end else passes++;
    cycle();
    checks++; if (empty !== 1'b1 || rd_valid !== 1'b0 || count !== 5'd0) begin fails++; $display("FAIL post_reset_idle got e=%b v=%b c=%0d want 1/0/0", empty, rd_valid, count); end else passes++;
  endtask

  task automatic test_fill_drain();
    for (int k = 1; k <= 16; k++) begin
      wr_en = 1'b1;
      wr_data = 8'(k);
      cycle();
      checks++; if (count !== 5'(k)) begin fails++; $display("FAIL fill_count[%0d] got=%0d want=%0d", k, count, k); end else passes++;
      checks++; if (almost_full !== (k >= 14)) begin fails++; $display("FAIL fill_af[%0d] got=%b want=%b", k, almost_full, (k >= 14)); end else passes++;
      checks++; if (almost_empty !== (k <= 2)) begin fails++; $display("FAIL fill_ae[%0d] got=%b want=%b", k, almost_empty, (k <= 2)); end else passes++;
      checks++; if (empty !== 1'b0) begin fails++; $display("FAIL fill_empty[%0d] got=%b want=0", k, empty); end else passes++;
    end
    idle();
    checks++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full got=%b want=1", full); end else passes++;
    for (int k = 1; k <= 16; k++) begin
      rd_en = 1'b1;
      cycle();
      checks++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL drain_valid[%0d] got=%b want=1", k, rd_valid); end else passes++;
      checks++; if (rd_data !== 8'(k)) begin fails++; $display("FAIL drain_data[%0d] got=%h want=%h", k, rd_data, 8'(k)); end else passes++;
      checks++; if (count !== 5'(16 - k)) begin fails++; $display("FAIL drain_count[%0d] got=%0d want=%0d", k, count, 16 - k); end else passes++;
    end
    idle();
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL drain_empty got e=%b f=%b want 1/0", empty, full); end else passes++;
    cycle();
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL drain_valid_drop got=%b want=0", rd_valid); end else passes++;
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1;
      wr_data = 8'h20 + 8'(k);
      cycle();
    end
    wr_en = 1'b1;
    wr_data = 8'hAA;
    cycle();
    idle();
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_pulse got=%b want=1", overflow); end else passes++;
    checks++; if (count !== 5'd16 || full !== 1'b1) begin fails++; $display("FAIL ovf_count got c=%0d f=%b want 16/1", count, full); end else passes++;
    cycle();
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_one_cycle got=%b want=0", overflow); end else passes++;
    for (int k = 0; k < 16; k++) begin
      rd_en = 1'b1;
      cycle();
      checks++; if (rd_data !== 8'h20 + 8'(k)) begin fails++; $display("FAIL ovf_drain[%0d] got=%h want=%h", k, rd_data, 8'h20 + 8'(k)); end else passes++;
    end
    idle();
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL ovf_empty got=%b want=1", empty); end else passes++;
    cycle();
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    cycle();
    idle();
    checks++; if (underflow !== 1'b1) begin fails++; $display("FAIL unf_pulse got=%b want=1", underflow); end else passes++;
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL unf_valid got=%b want=0", rd_valid); end else passes++;
    checks++; if (rd_data !== 8'h2F) begin fails++; $display("FAIL unf_hold got=%h want=2f", rd_data); end else passes++;
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h55;
    cycle();
    idle();
    checks++; if (count !== 5'd1 || empty !== 1'b0) begin fails++; $display("FAIL unf_wr_count got c=%0d e=%b want 1/0", count, empty); end else passes++;
    checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin fails++; $display("FAIL unf_wr_pulse got un=%b v=%b want 1/0", underflow, rd_valid); end else passes++;
    cycle();
    checks++; if (underflow !== 1'b0) begin fails++; $display("FAIL unf_one_cycle got=%b want=0", underflow); end else passes++;
    rd_en = 1'b1;
    cycle();
    idle();
    checks++; if (rd_data !== 8'h55 || rd_valid !== 1'b1) begin fails++; $display("FAIL unf_read55 got d=%h v=%b want 55/1", rd_data, rd_valid); end else passes++;
    checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin fails++; $display("FAIL unf_after got e=%b un=%b want 1/0", empty, underflow); end else passes++;
    cycle();
  endtask

  task automatic test_full_rw();
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1;
      wr_data = 8'h80 + 8'(k);
      cycle();
    end
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h90;
    cycle();
    idle();
    checks++; if (count !== 5'd16 || full !== 1'b1) begin fails++; $display("FAIL full_rw_count got c=%0d f=%b want 16/1", count, full); end else passes++;
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_rw_ovf got=%b want=0", overflow); end else passes++;
    checks++; if (rd_data !== 8'h80 || rd_valid !== 1'b1) begin fails++; $display("FAIL full_rw_data got d=%h v=%b want 80/1", rd_data, rd_valid); end else passes++;
    for (int k = 1; k <= 16; k++) begin
      rd_en = 1'b1;
      cycle();
      checks++; if (rd_data !== 8'h80 + 8'(k)) begin fails++; $display("FAIL full_rw_drain[%0d] got=%h want=%h", k, rd_data, 8'h80 + 8'(k)); end else passes++;
    end
    idle();
    cycle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1;
      wr_data = 8'h40 + 8'(k);
      cycle();
    end
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = 8'h45 + 8'(k);
      cycle();
      checks++; if (count !== 5'd5) begin fails++; $display("FAIL b2b_count[%0d] got=%0d want=5", k, count); end else passes++;
      checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h40 + 8'(k)) begin fails++; $display("FAIL b2b_data[%0d] got d=%h v=%b want %h/1", k, rd_data, rd_valid, 8'h40 + 8'(k)); end else passes++;
    end
    idle();
    for (int k = 0; k < 5; k++) begin
      rd_en = 1'b1;
      cycle();
      checks++; if (rd_data !== 8'h68 + 8'(k)) begin fails++; $display("FAIL b2b_tail[%0d] got=%h want=%h", k, rd_data, 8'h68 + 8'(k)); end else passes++;
    end
    idle();
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got=%b want=1", empty); end else passes++;
    cycle();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1;
      wr_data = 8'hA0 + 8'(k);
      cycle();
    end
    checks++; if (count !== 5'd10) begin fails++; $display("FAIL mid_pre_count got=%0d want=10", count); end else passes++;
    rst_n = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'hEE;
    cycle();
    rst_n = 1'b0;
    idle();
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin fails++; $display("FAIL mid_reset got c=%0d e=%b want 0/1", count, empty); end else passes++;
    checks++; if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_rd got d=%h v=%b want 00/0", rd_data, rd_valid); end else passes++;
    wr_en = 1'b1;
    wr_data = 8'h3C;
    cycle();
    idle();
    checks++; if (count !== 5'd1) begin fails++; $display("FAIL mid_wr_count got=%0d want=1", count); end else passes++;
    rd_en = 1'b1;
    cycle();
    idle();
    checks++; if (rd_data !== 8'h3C || rd_valid !== 1'b1) begin fails++; $display("FAIL mid_read got d=%h v=%b want 3c/1", rd_data, rd_valid); end else passes++;
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin fails++; $display("FAIL mid_empty got e=%b c=%0d want 1/0", empty, count); end else passes++;
    cycle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_rw();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock synchronous FIFO for buffering data words between two producer/consumer blocks in the same clock domain. Writes and reads are enabled by independent strobes, status flags are exposed for flow control, and the read data port is registered. This block serves as a general-purpose rate-matching buffer inside the datapath.

## Interface
- DATA_WIDTH, 8, width of each stored word
- DEPTH, 16, number of entries; must be a power of two, ≥ 4
- AF_LEVEL, DEPTH-2, count at or above which almost_full asserts
- AE_LEVEL, 2, count at or below which almost_empty asserts
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  synchronous reset, active-high (rst_n=1 resets on a rising clk edge, despite the name)
- wr_en  input  1  write request
- wr_data  input  DATA_WIDTH  write word
- rd_en  input  1  read request
- rd_data  output  DATA_WIDTH  registered read word
- rd_valid  output  1  rd_data holds a word popped on the previous edge
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write rejected
- underflow  output  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH x DATA_WIDTH register array; write and read pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0 naturally.
- Write accepted when wr_en && (!full || rd_en): the word is stored at wr_ptr and wr_ptr increments.
- Read accepted when rd_en && !empty: rd_data <= mem[rd_ptr], rd_ptr increments, rd_valid=1 next cycle; otherwise rd_valid=0 and rd_data holds its value.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with both wr_en and rd_en: both accepted, count stays DEPTH, no overflow.
- Empty with both wr_en and rd_en: write accepted, read rejected (no fall-through), underflow pulses, count becomes 1.
- overflow = wr_en && full && !rd_en, registered; underflow = rd_en && empty, registered. Rejected operations change no state.
- Flags are derived combinationally from the registered count.
- Reset: pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; therefore empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not cleared. Reset has priority over any concurrent wr_en/rd_en, and reset mid-operation discards all contents.
- Inputs that are X while reset is asserted must not propagate to outputs after reset deasserts.

## Timing
- Write-to-visible: a word written at edge N can be read at edge N+1 (empty deasserts after edge N); rd_data is valid after edge N+1.
- Read latency: 1 cycle from the rd_en sampling edge to rd_data/rd_valid.
- Flags and count update on the same edge as the pointer change; no combinational path from wr_en/rd_en to any output.
- overflow/underflow are asserted for exactly the cycle following the offending request.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Hold rst_n=1 for 3 edges with other inputs at X, then drop to 0 -> empty=1, full=0, count=0, rd_data=0, rd_valid=0.
- Write 0x01..0x10 (16 words) then read 16 -> rd_data sequence 0x01..0x10 with rd_valid=1 each cycle; full=1 after the 16th write; empty=1 after the 16th read.
- When full, wr_en=1 with rd_en=0 and wr_data=0xAA -> overflow pulses once, count stays 16, 0xAA never appears on rd_data.
- When empty, rd_en=1 -> underflow pulses, rd_valid=0, rd_data unchanged; simultaneous wr_en=1 with 0x55 -> count=1, next read returns 0x55.
- Write 5 words, then assert wr_en and rd_en together for 40 cycles -> count stays 5, output in order, pointers wrap cleanly.
- Write 10 words, assert rst_n=1 for one edge -> count=0, empty=1; a subsequent write/read of 0x3C returns 0x3C.
